// File: rtl/fetch_pc_select.sv
// F-stage PC selection and predicted-PC register for the pipelined Y86-64 core.
// Chooses the fetch address, predicts the next PC, and blocks fetch behind ret/halt.
module fetch_pc_select #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F_stall,
  input  logic [3:0]       f_icode,
  input  logic [63:0]      f_valC,
  input  logic [63:0]      f_valP,
  input  logic [3:0]       M_icode,
  input  logic             M_cnd,
  input  logic [63:0]      M_valA,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valM,
  output logic [63:0]      f_pc,
  output logic [63:0]      F_predPC,
  output logic             fetch_valid,
  output logic [1:0]       fstate,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [3:0] IHalt = 4'h0;
  localparam logic [3:0] IJxx  = 4'h7;
  localparam logic [3:0] ICall = 4'h8;
  localparam logic [3:0] IRet  = 4'h9;
  localparam logic [3:0] IMax  = 4'hB;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StRetWait = 2'd1,
    StHalt    = 2'd2
  } fstate_e;

  fstate_e          state_q, state_d;
  logic [63:0]      pred_q, pred_next;
  logic [CNT_W-1:0] cnt_q;
  logic             mispredict, retdone, correction, accept, valid;

  always_comb begin
    mispredict = (M_icode == IJxx) && !M_cnd;
    retdone    = (W_icode == IRet);

    if (mispredict)   f_pc = M_valA;
    else if (retdone) f_pc = W_valM;
    else              f_pc = pred_q;

    pred_next = ((f_icode == IJxx) || (f_icode == ICall)) ? f_valC : f_valP;

    // Corrections redirect fetch onto the architected path and cannot be stalled.
    correction = mispredict || ((state_q == StRetWait) && retdone);
    valid      = (state_q == StRun) || correction;
    accept     = correction || (valid && !F_stall);

    state_d = state_q;
    if (accept) begin
      if (f_icode == IRet)                          state_d = StRetWait;
      else if ((f_icode == IHalt) || (f_icode > IMax)) state_d = StHalt;
      else                                          state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pred_q  <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pred_q <= pred_next;
        cnt_q  <= cnt_q + CntOne;
      end
    end
  end

  assign F_predPC    = pred_q;
  assign fetch_valid = valid;
  assign fstate      = state_q;
  assign fetch_count = cnt_q;

endmodule
